// File: rtl/mau_pkg.sv
// ---------------------------------------------------------------
// mau_pkg : op encodings, FSM states and parameter checks for mau_iter
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none
package mau_pkg;

  localparam logic [1:0] MAU_MADD  = 2'b00;
  localparam logic [1:0] MAU_MADDU = 2'b01;
  localparam logic [1:0] MAU_MUL   = 2'b10;
  localparam logic [1:0] MAU_CLR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } mau_state_t;

  function automatic logic mau_bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mau_iter_if.sv
// ---------------------------------------------------------------
// mau_iter_if : start/ready/done request bus and hi/lo result of mau_iter
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none
interface mau_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input ready, busy, done, hi, lo);
  modport slave  (input start, op, a, b, output ready, busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mau_shift_add_step.sv
// ---------------------------------------------------------------
// mau_shift_add_step : one radix-2^BPC iteration, next = partial + (mcand*slice) << (k*BPC)
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none
module mau_shift_add_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int KW             = 6
) (
  input  logic [2*WIDTH-1:0]        i_partial,
  input  logic [WIDTH-1:0]          i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_slice,
  input  logic [KW-1:0]             i_k,
  output logic [2*WIDTH-1:0]        o_next
);
  localparam int LOG_BPC = $clog2(BITS_PER_CYCLE);

  logic [2*WIDTH-1:0] w_mcand_ext;
  logic [2*WIDTH-1:0] w_slice_ext;
  logic [2*WIDTH-1:0] w_term;
  logic [KW+1:0]      w_shamt;

  assign w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};
  assign w_slice_ext = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, i_slice};
  assign w_shamt     = {2'b00, i_k} << LOG_BPC;
  assign w_term      = (w_mcand_ext * w_slice_ext) << w_shamt;
  assign o_next      = i_partial + w_term;
endmodule
`default_nettype wire

// File: rtl/mau_iter.sv
// ---------------------------------------------------------------
// mau_iter : multi-cycle shift-add multiply-accumulate with hi/lo accumulator.
// Optional MAU_EARLY_TERM_EN ends the MULT phase once the remaining multiplier is zero.
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none
module mau_iter
  import mau_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic      clk,
  input  logic      reset,
  mau_iter_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int KW = $clog2(N + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if (!mau_bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bpc_illegal
      $error("mau_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  mau_state_t         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               w_signed_op;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_mplier_shift;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_p;

  // Magnitudes are taken in WIDTH bits: -MIN wraps back to 2^(WIDTH-1), which is the exact magnitude.
  assign w_signed_op    = (bus.op != MAU_MADDU);
  assign w_a_abs        = (w_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_abs        = (w_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_mplier_shift = mplier_q >> BITS_PER_CYCLE;
  assign w_p            = neg_q ? -prod_q : prod_q;

  mau_shift_add_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .KW             (KW)
  ) u_step (
    .i_partial (prod_q),
    .i_mcand   (mcand_q),
    .i_slice   (mplier_q[BITS_PER_CYCLE-1:0]),
    .i_k       (k_q),
    .o_next    (w_step)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    op_d     = op_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    k_d      = k_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == MAU_CLR) begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = ST_DONE;
          end else begin
            op_d     = bus.op;
            mcand_d  = w_a_abs;
            mplier_d = w_b_abs;
            neg_d    = w_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            prod_d   = '0;
            k_d      = '0;
            state_d  = ST_MULT;
          end
        end
      end
      ST_MULT: begin
        prod_d   = w_step;
        mplier_d = w_mplier_shift;
        k_d      = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_ACC;
        end
`ifdef MAU_EARLY_TERM_EN
        else if (w_mplier_shift == '0) begin
          state_d = ST_ACC;
        end
`endif
      end
      ST_ACC: begin
        if (op_q == MAU_MUL) begin
          {hi_d, lo_d} = w_p;
        end else begin
          {hi_d, lo_d} = {hi_q, lo_q} + w_p;
        end
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      op_q     <= MAU_MADD;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      k_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      k_q      <= k_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule
`default_nettype wire
